water_reminder_multi: RTL and testbench
=======================================

WATER_REMINDER_MULTI -- requirements
Module: water_reminder_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent bottle channels.
REQ-002 SHALL have parameter LEVEL_W, default 4: water-level width per channel.
REQ-003 SHALL have parameter LOW_THRESH, default 3: refill threshold, inclusive.
REQ-004 SHALL have parameter TIMEOUT, default 60: cycles without a drink before a reminder.
REQ-005 SHALL have parameter SNOOZE_CYC, default 30: snooze length in cycles.
REQ-006 SHALL have parameters START_HOUR, default 8, and END_HOUR, default 22: active window is START_HOUR <= hour < END_HOUR.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port water_level, input, NUM_CH*LEVEL_W bits: channel c occupies bits [c*LEVEL_W +: LEVEL_W].
REQ-010 SHALL have ports hMSD and hLSD, input, 4 bits each: BCD tens and units of the current hour.
REQ-011 SHALL have port ack, input, NUM_CH bits: per-channel snooze request, level-sampled.
REQ-012 SHALL have port remind, output, NUM_CH bits: registered per-channel drink reminder.
REQ-013 SHALL have port refill, output, NUM_CH bits: registered per-channel low-level flag.
REQ-014 SHALL have port any_remind, output, 1 bit: registered OR of all remind bits.

Function
REQ-015 SHALL decode hour = 10*hMSD + hLSD; a digit > 9 or hour > 23 SHALL count as outside the window.
REQ-016 SHALL register each channel's level every cycle as prev_level; drink = current level < prev_level; a level increase (refill) SHALL NOT count as a drink.
REQ-017 Each channel SHALL run an FSM with states IDLE, TRACK, REMIND, SNOOZE and a cycle counter sized $clog2(max(TIMEOUT, SNOOZE_CYC)+1).
REQ-018 IDLE->TRACK when in window, with counter cleared; any state->IDLE when out of window, with counter cleared; this transition SHALL have highest priority.
REQ-019 TRACK: a drink clears the counter; otherwise the counter increments; at counter == TIMEOUT-1 with no drink, next state is REMIND.
REQ-020 With TRACK entered at edge k and no drinks, remind SHALL rise immediately after edge k+TIMEOUT.
REQ-021 REMIND: a drink goes to TRACK with counter cleared; otherwise ack goes to SNOOZE with counter cleared; drink SHALL win over simultaneous ack.
REQ-022 SNOOZE: a drink goes to TRACK; otherwise the counter increments, and at counter == SNOOZE_CYC-1 the next state is REMIND; ack is ignored in SNOOZE.
REQ-023 remind[c] SHALL be registered as (next state == REMIND), so it changes in the same cycle as the state register.
REQ-024 refill[c] SHALL be registered as (water_level[c] <= LOW_THRESH), independent of the window and FSM; one cycle latency.
REQ-025 any_remind SHALL equal the OR of the next-state remind bits, registered alongside remind.

Reset
REQ-026 While reset is low: all FSMs IDLE, counters 0, prev_level 0, and remind, refill, any_remind all 0, asynchronously.
REQ-027 Reset asserted mid-REMIND or mid-SNOOZE SHALL drop remind within the same cycle; no state is retained.
REQ-028 After reset release, the first sampled level SHALL never register as a drink, because prev_level is 0.

Configuration
REQ-029 Macro WATER_REMINDER_SNOOZE_EN defined: SNOOZE state and ack behaviour exactly as in REQ-021/022.
REQ-030 Macro undefined: SNOOZE state not implemented; the ack port still exists but is ignored; REMIND exits only on drink or window exit.

Structure
REQ-031 Package water_reminder_pkg SHALL hold the state enum, the hour-window defaults and a bcd_to_hour function that returns an invalid flag.
REQ-032 Sub-module reminder_channel SHALL implement one channel (FSM, counter, prev_level, refill), generated NUM_CH times; hour decode and any_remind live at top level.

Verification (bench parameters: NUM_CH=2, TIMEOUT=8, SNOOZE_CYC=4, LOW_THRESH=3)
REQ-033 hour 10, level held at F -> remind[0]=1 exactly 8 cycles after TRACK entry; any_remind=1.
REQ-034 In REMIND, level F->E -> remind[0]=0 next cycle; the 8-cycle count restarts.
REQ-035 In REMIND, ack[0]=1 for 1 cycle -> remind low 4 cycles, then high again (snooze build); with macro undefined, remind stays high.
REQ-036 hour 21->22 while in REMIND -> remind=0 next cycle; hMSD=2, hLSD=A -> treated as out of window, remind stays 0.
REQ-037 level 4->3 -> refill=1 next cycle, and also at hour 03; level 3->F -> refill=0, not a drink, and the counter keeps running.
REQ-038 reset low mid-SNOOZE -> all outputs 0 immediately; after release, in window, a full 8-cycle TIMEOUT is needed before remind.

Source files
------------

// File: rtl/water_reminder_pkg.sv
// Shared types for the multi-bottle water reminder: channel state encoding,
// debug record, default hour window and BCD hour decode.
package water_reminder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_REMIND = 2'd2,
    ST_SNOOZE = 2'd3
  } ch_state_t;

  localparam int DEF_START_HOUR = 8;
  localparam int DEF_END_HOUR   = 22;

  typedef struct packed {
    logic       invalid;
    logic [6:0] hour;
  } hour_t;

  // Per-channel observation record: current state plus the two FSM inputs.
  typedef struct packed {
    ch_state_t state;
    logic      drink;
    logic      ack;
  } ch_dbg_t;

  // Hour digits outside 0..9, or a decoded hour above 23, flag as invalid.
  function automatic hour_t bcd_to_hour(input logic [3:0] msd, input logic [3:0] lsd);
    hour_t r;
    r.hour    = 7'(msd) * 7'd10 + 7'(lsd);
    r.invalid = (msd > 4'd9) || (lsd > 4'd9) || (r.hour > 7'd23);
    return r;
  endfunction

endpackage

// File: rtl/reminder_channel.sv
// One bottle channel: drink detection, reminder FSM with cycle counter, low-level flag.
// Snooze handling is built only when WATER_REMINDER_SNOOZE_EN is defined.
module reminder_channel
  import water_reminder_pkg::*;
#(
  parameter int LEVEL_W    = 4,
  parameter int LOW_THRESH = 3,
  parameter int TIMEOUT    = 60,
  parameter int SNOOZE_CYC = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_window,
  input  logic [LEVEL_W-1:0] level,
  input  logic               ack,
  output logic               remind,
  output logic               remind_nxt,
  output logic               refill,
  output ch_dbg_t            dbg
);

  localparam int CNT_MAX = (TIMEOUT > SNOOZE_CYC) ? TIMEOUT : SNOOZE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ch_state_t          state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LEVEL_W-1:0] prev_level;
  logic               drink;

  // A rising level is a refill, never a drink.
  assign drink = level < prev_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prev_level <= '0;
      remind     <= 1'b0;
      refill     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      prev_level <= level;
      remind     <= remind_nxt;
      refill     <= (level <= LEVEL_W'(LOW_THRESH));
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!in_window) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_TRACK;
          cnt_n   = '0;
        end
        ST_TRACK: begin
          if (drink) begin
            cnt_n = '0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state_n = ST_REMIND;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_REMIND: begin
          if (drink) begin
            state_n = ST_TRACK;
            cnt_n   = '0;
          end
`ifdef WATER_REMINDER_SNOOZE_EN
          else if (ack) begin
            state_n = ST_SNOOZE;
            cnt_n   = '0;
          end
`endif
        end
`ifdef WATER_REMINDER_SNOOZE_EN
        ST_SNOOZE: begin
          if (drink) begin
            state_n = ST_TRACK;
            cnt_n   = '0;
          end else if (cnt == CNT_W'(SNOOZE_CYC - 1)) begin
            state_n = ST_REMIND;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
`endif
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    remind_nxt = (state_n == ST_REMIND);
    dbg        = '{state: state, drink: drink, ack: ack};
  end

endmodule

// File: rtl/water_reminder_multi.sv
// Multi-channel water reminder: shared hour-window decode, NUM_CH reminder channels,
// registered any_remind. Optional snooze via WATER_REMINDER_SNOOZE_EN.
module water_reminder_multi
  import water_reminder_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int LEVEL_W    = 4,
  parameter int LOW_THRESH = 3,
  parameter int TIMEOUT    = 60,
  parameter int SNOOZE_CYC = 30,
  parameter int START_HOUR = DEF_START_HOUR,
  parameter int END_HOUR   = DEF_END_HOUR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*LEVEL_W-1:0] water_level,
  input  logic [3:0]                hMSD,
  input  logic [3:0]                hLSD,
  input  logic [NUM_CH-1:0]         ack,
  output logic [NUM_CH-1:0]         remind,
  output logic [NUM_CH-1:0]         refill,
  output logic                      any_remind,
  output ch_dbg_t [NUM_CH-1:0]      dbg
);

  hour_t             hr;
  logic              in_window;
  logic [NUM_CH-1:0] remind_nxt;

  assign hr        = bcd_to_hour(hMSD, hLSD);
  assign in_window = !hr.invalid && (hr.hour >= 7'(START_HOUR)) && (hr.hour < 7'(END_HOUR));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    reminder_channel #(
      .LEVEL_W   (LEVEL_W),
      .LOW_THRESH(LOW_THRESH),
      .TIMEOUT   (TIMEOUT),
      .SNOOZE_CYC(SNOOZE_CYC)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .in_window (in_window),
      .level     (water_level[c*LEVEL_W +: LEVEL_W]),
      .ack       (ack[c]),
      .remind    (remind[c]),
      .remind_nxt(remind_nxt[c]),
      .refill    (refill[c]),
      .dbg       (dbg[c])
    );
  end

  // Built from next-state bits so it moves in the same cycle as remind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) any_remind <= 1'b0;
    else        any_remind <= |remind_nxt;
  end

endmodule

// File: tb/tb_water_reminder_multi.sv
// Directed bench for water_reminder_multi: hour-window/refill vector table plus
// hand-written reminder, drink, snooze, window-exit and reset sequences.
module tb_water_reminder_multi;
  import water_reminder_pkg::*;

  localparam int NUM_CH = 2, LEVEL_W = 4, LOW_THRESH = 3, TIMEOUT = 8, SNOOZE_CYC = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_CH*LEVEL_W-1:0] water_level = '0;
  logic [3:0]                hmsd = '0, hlsd = '0;
  logic [NUM_CH-1:0]         ack = '0;
  logic [NUM_CH-1:0]         remind, refill;
  logic                      any_remind;
  ch_dbg_t [NUM_CH-1:0]      dbg;

  int n_cmp = 0;
  int n_bad = 0;

  water_reminder_multi #(
    .NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W), .LOW_THRESH(LOW_THRESH),
    .TIMEOUT(TIMEOUT), .SNOOZE_CYC(SNOOZE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .water_level(water_level), .hMSD(hmsd), .hLSD(hlsd),
    .ack(ack), .remind(remind), .refill(refill), .any_remind(any_remind), .dbg(dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] m, l, lvl0, lvl1;
    ch_state_t  exp_state;
    logic [1:0] exp_refill;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [3:0] m, input logic [3:0] l,
                       input logic [3:0] lvl0, input logic [3:0] lvl1);
    hmsd        = m;
    hlsd        = l;
    water_level = {lvl1, lvl0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ack   = '0;
    step(2);
    reset = 1'b1;
  endtask

  // n-1 cycles with remind[ch] low, then high on the n-th.
  task automatic expect_remind_after(input string name, input int ch, input int n);
    int early = 0;
    for (int i = 0; i < n - 1; i++) begin
      step();
      if (remind[ch] !== 1'b0) early++;
    end
    check({name, "_early"}, early, 0);
    step();
    check({name, "_rise"}, remind[ch], 1'b1);
  endtask

  initial begin
    vecs[0]  = '{4'd0, 4'd3, 4'h3, 4'hF, ST_IDLE,  2'b01};
    vecs[1]  = '{4'd1, 4'd0, 4'h4, 4'h3, ST_TRACK, 2'b10};
    vecs[2]  = '{4'd0, 4'd7, 4'h0, 4'h4, ST_IDLE,  2'b01};
    vecs[3]  = '{4'd0, 4'd8, 4'hF, 4'h0, ST_TRACK, 2'b10};
    vecs[4]  = '{4'd2, 4'd2, 4'h2, 4'h2, ST_IDLE,  2'b11};
    vecs[5]  = '{4'd2, 4'd1, 4'h5, 4'h9, ST_TRACK, 2'b00};
    vecs[6]  = '{4'd2, 4'hA, 4'h3, 4'h3, ST_IDLE,  2'b11};
    vecs[7]  = '{4'd1, 4'd9, 4'h4, 4'h4, ST_TRACK, 2'b00};
    vecs[8]  = '{4'hA, 4'd0, 4'h1, 4'h8, ST_IDLE,  2'b01};
    vecs[9]  = '{4'd1, 4'd2, 4'h7, 4'h1, ST_TRACK, 2'b10};
    vecs[10] = '{4'd2, 4'd4, 4'hF, 4'hF, ST_IDLE,  2'b00};
    vecs[11] = '{4'd0, 4'd9, 4'h3, 4'h4, ST_TRACK, 2'b01};
    vecs[12] = '{4'd3, 4'd0, 4'hE, 4'h0, ST_IDLE,  2'b10};
    vecs[13] = '{4'd1, 4'hB, 4'h6, 4'h6, ST_IDLE,  2'b00};
    vecs[14] = '{4'd1, 4'd5, 4'h0, 4'h0, ST_TRACK, 2'b11};

    // reset state
    drive(4'd0, 4'd0, 4'hF, 4'hF);
    #1;
    check("rst_remind", remind, 2'b00);
    check("rst_refill", refill, 2'b00);
    check("rst_any", any_remind, 1'b0);
    check("rst_state0", dbg[0].state, ST_IDLE);
    do_reset();

    // hour window decode and refill flag
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].m, vecs[i].l, vecs[i].lvl0, vecs[i].lvl1);
      step();
      check($sformatf("tbl%0d_state0", i), dbg[0].state, vecs[i].exp_state);
      check($sformatf("tbl%0d_state1", i), dbg[1].state, vecs[i].exp_state);
      check($sformatf("tbl%0d_refill", i), refill, vecs[i].exp_refill);
    end

    // timeout from TRACK entry
    drive(4'd1, 4'd0, 4'hF, 4'hF);
    do_reset();
    expect_remind_after("a_timeout", 0, 9);
    check("a_any", any_remind, 1'b1);
    check("a_state0", dbg[0].state, ST_REMIND);

    // drink in REMIND restarts the count
    drive(4'd1, 4'd0, 4'hE, 4'hF);
    step();
    check("b_drop", remind, 2'b10);
    check("b_any", any_remind, 1'b1);
    expect_remind_after("b_restart", 0, 8);

    // ack in REMIND
    ack = 2'b01;
    step();
    ack = 2'b00;
`ifdef WATER_REMINDER_SNOOZE_EN
    check("c_snooze_drop", remind[0], 1'b0);
    check("c_snooze_state", dbg[0].state, ST_SNOOZE);
    expect_remind_after("c_snooze", 0, 4);
`else
    check("c_ack_ignored", remind[0], 1'b1);
    step(4);
    check("c_hold", remind[0], 1'b1);
`endif

    // leaving the window while reminding
    drive(4'd2, 4'd1, 4'hE, 4'hF);
    step();
    check("d_h21", remind, 2'b11);
    drive(4'd2, 4'd2, 4'hE, 4'hF);
    step();
    check("d_h22_remind", remind, 2'b00);
    check("d_h22_any", any_remind, 1'b0);
    drive(4'd2, 4'hA, 4'hE, 4'hF);
    step(3);
    check("d_badbcd_remind", remind, 2'b00);
    check("d_badbcd_state", dbg[0].state, ST_IDLE);

    // refill flag, and a level rise is not a drink
    drive(4'd0, 4'd3, 4'h4, 4'hF);
    do_reset();
    step();
    check("e_lvl4", refill, 2'b00);
    drive(4'd0, 4'd3, 4'h3, 4'hF);
    step();
    check("e_lvl3_h03", refill, 2'b01);
    drive(4'd1, 4'd0, 4'h3, 4'hF);
    step();
    check("e_track", dbg[0].state, ST_TRACK);
    step(3);
    drive(4'd1, 4'd0, 4'hF, 4'hF);
    step();
    check("e_refill_clear", refill, 2'b00);
    check("e_no_drink", dbg[0].drink, 1'b0);
    expect_remind_after("e_count_kept", 0, 4);

    // asynchronous reset mid-snooze
    drive(4'd1, 4'd0, 4'hF, 4'h2);
    do_reset();
    expect_remind_after("f_pre", 0, 9);
    ack = 2'b01;
    step();
    ack = 2'b00;
    step();
    check("f_pre_refill", refill, 2'b10);
    check("f_pre_remind1", remind[1], 1'b1);
    #2 reset = 1'b0;
    #1;
    check("f_async_remind", remind, 2'b00);
    check("f_async_refill", refill, 2'b00);
    check("f_async_any", any_remind, 1'b0);
    check("f_async_state0", dbg[0].state, ST_IDLE);
    @(negedge clk);
    step();
    reset = 1'b1;
    expect_remind_after("f_post", 0, 9);
    check("f_post_refill", refill, 2'b10);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
